// File: rtl/perf_arb_pkg.sv
// Shared types and constants for the two-lane (A+B)*4+C operation arbiter.
// Lane tags travel alongside data through the compute pipeline.
package perf_arb_pkg;

    localparam int NUM_REQ  = 2;
    localparam int OP_W     = 32;
    localparam int RES_W    = 36;
    localparam int SUM_W    = OP_W + 1;
    localparam int PIPE_LAT = 3;

    typedef logic [$clog2(NUM_REQ)-1:0] lane_t;

    typedef struct packed {
        logic  vld;
        lane_t lane;
    } tag_t;

endpackage

// File: rtl/perf_op_pipe.sv
// Three-stage (A+B)*4+C datapath with a lane-tag sidecar.
// Only the tag valids are reset; data registers run free.
module perf_op_pipe
    import perf_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  lane_t            in_lane,
    input  logic [OP_W-1:0]  in_a,
    input  logic [OP_W-1:0]  in_b,
    input  logic [OP_W-1:0]  in_c,
    output logic             out_valid,
    output lane_t            out_lane,
    output logic [RES_W-1:0] out_res
);

    tag_t              tag_q [PIPE_LAT];
    logic [OP_W-1:0]   s1_a;
    logic [OP_W-1:0]   s1_b;
    logic [OP_W-1:0]   s1_c;
    logic [SUM_W-1:0]  s2_sum;
    logic [OP_W-1:0]   s2_c;
    logic [RES_W-1:0]  s3_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < PIPE_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0] <= '{vld: in_valid, lane: in_lane};
            for (int k = 1; k < PIPE_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        s1_a   <= in_a;
        s1_b   <= in_b;
        s1_c   <= in_c;
        s2_sum <= {1'b0, s1_a} + {1'b0, s1_b};
        s2_c   <= s1_c;
        // Times-four is a 2-bit shift of the 33-bit sum.
        s3_res <= {1'b0, s2_sum, 2'b00} + {4'b0000, s2_c};
    end

    assign out_valid = tag_q[PIPE_LAT-1].vld;
    assign out_lane  = tag_q[PIPE_LAT-1].lane;
    assign out_res   = s3_res;

endmodule

// File: rtl/perf_op_arbiter.sv
// Round-robin, credit-gated arbiter feeding a shared op pipe and per-lane
// result FIFOs. Define PERF_ARB_STATS_EN to add saturating grant counters.
module perf_op_arbiter
    import perf_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*OP_W-1:0]  req_a,
    input  logic [NUM_REQ*OP_W-1:0]  req_b,
    input  logic [NUM_REQ*OP_W-1:0]  req_c,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [NUM_REQ*RES_W-1:0] rsp_data,
    output logic                     busy
`ifdef PERF_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]    grant_cnt
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

    logic [CW-1:0]    inflight [NUM_REQ];
    logic [CW-1:0]    fcnt     [NUM_REQ];
    logic [PW-1:0]    wptr     [NUM_REQ];
    logic [PW-1:0]    rptr     [NUM_REQ];
    logic [RES_W-1:0] mem      [NUM_REQ][FIFO_DEPTH];

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;
    logic [CW:0]        occ;
    lane_t              last_lane;
    lane_t              hs_lane;
    logic [OP_W-1:0]    op_a;
    logic [OP_W-1:0]    op_b;
    logic [OP_W-1:0]    op_c;

    logic               pipe_vld;
    lane_t              pipe_lane;
    logic [RES_W-1:0]   pipe_res;

    // Credit covers both in-flight ops and buffered results, so a
    // FIFO can never be overrun by ops already in the pipe.
    always_comb begin
        elig = '0;
        occ  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            occ     = {1'b0, inflight[i]} + {1'b0, fcnt[i]};
            elig[i] = req_valid[i] && (occ < DEPTH_V);
        end
    end

    always_comb begin
        grant = '0;
        if (!rst) begin
            unique case (elig)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (last_lane == lane_t'(0)) ? 2'b10 : 2'b01;
                default: grant = '0;
            endcase
        end
    end

    always_comb begin
        hs_lane = '0;
        op_a    = '0;
        op_b    = '0;
        op_c    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                hs_lane = lane_t'(i);
                op_a    = req_a[i*OP_W +: OP_W];
                op_b    = req_b[i*OP_W +: OP_W];
                op_c    = req_c[i*OP_W +: OP_W];
            end
        end
    end

    assign req_ready = grant;

    perf_op_pipe u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (|grant),
        .in_lane   (hs_lane),
        .in_a      (op_a),
        .in_b      (op_b),
        .in_c      (op_c),
        .out_valid (pipe_vld),
        .out_lane  (pipe_lane),
        .out_res   (pipe_res)
    );

    always_comb begin
        push      = '0;
        pop       = '0;
        rsp_valid = '0;
        rsp_data  = '0;
        busy      = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            push[i]      = pipe_vld && (pipe_lane == lane_t'(i));
            rsp_valid[i] = !rst && (fcnt[i] != '0);
            pop[i]       = rsp_valid[i] && rsp_ready[i];
            rsp_data[i*RES_W +: RES_W] = mem[i][rptr[i]];
            busy = busy || (inflight[i] != '0) || (fcnt[i] != '0);
        end
        busy = busy && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_lane <= lane_t'(NUM_REQ - 1);
            for (int i = 0; i < NUM_REQ; i++) begin
                inflight[i] <= '0;
                fcnt[i]     <= '0;
                wptr[i]     <= '0;
                rptr[i]     <= '0;
            end
        end else begin
            if (|grant) begin
                last_lane <= hs_lane;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                inflight[i] <= inflight[i] + CW'(grant[i]) - CW'(push[i]);
                fcnt[i]     <= fcnt[i] + CW'(push[i]) - CW'(pop[i]);
                wptr[i]     <= wptr[i] + PW'(push[i]);
                rptr[i]     <= rptr[i] + PW'(pop[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push[i]) begin
                mem[i][wptr[i]] <= pipe_res;
            end
        end
    end

`ifdef PERF_ARB_STATS_EN
    logic [15:0] gcnt [NUM_REQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                gcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] && (gcnt[i] != 16'hFFFF)) begin
                    gcnt[i] <= gcnt[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt[i*16 +: 16] = gcnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_perf_op_arbiter.sv
// Self-checking bench: directed vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_perf_op_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [63:0] req_c = '0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = '0;
    logic [71:0] rsp_data;
    logic        busy;
`ifdef PERF_ARB_STATS_EN
    logic [31:0] grant_cnt;
`endif

    always #5 clk = ~clk;

    perf_op_arbiter #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
`ifdef PERF_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          lane;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [35:0] exp;
    } vec_t;

    typedef struct {
        logic [35:0] res;
        int          avail;
    } ent_t;

    vec_t vt [7];
    ent_t q0 [$];
    ent_t q1 [$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [35:0] lane_data(input int l);
        return rsp_data[l*36 +: 36];
    endfunction

    function automatic logic [35:0] ref_res(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] c);
        longint unsigned s;
        s = 64'(a) + 64'(b);
        return 36'(s * 4 + 64'(c));
    endfunction

    function automatic int qsize(input int l);
        return (l == 0) ? q0.size() : q1.size();
    endfunction

    function automatic ent_t qfront(input int l);
        return (l == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(input int l);
        if (l == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
    endtask

    task automatic qpush(input int l, input ent_t e);
        if (l == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic put_op(input int l, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] c);
        req_a[l*32 +: 32] = a;
        req_b[l*32 +: 32] = b;
        req_c[l*32 +: 32] = c;
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        @(posedge clk);
        #1;
        req_valid = 2'b11;
        #1;
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          hs;
        int          now;
        int          pref;
        int          g;
        int          gc [2];
        logic [1:0]  el;
        logic [1:0]  erdy;
        logic [1:0]  ev;
        logic        eb;
        ent_t        e;

        vt[0] = '{0, 32'd1, 32'd2, 32'd3, 36'd15};
        vt[1] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 36'h8FFFFFFF7};
        vt[2] = '{1, 32'd1, 32'd2, 32'd3, 36'd15};
        vt[3] = '{1, 32'hFFFFFFFF, 32'd1, 32'd0, 36'h400000000};
        vt[4] = '{0, 32'd0, 32'd0, 32'd0, 36'd0};
        vt[5] = '{1, 32'h12345678, 32'h11111111, 32'd5, 36'h08D159E29};
        vt[6] = '{0, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 36'h4FFFFFFFF};

        do_reset;

        // Directed vectors: latency of three edges, then exact result.
        for (int v = 0; v < 7; v++) begin
            put_op(vt[v].lane, vt[v].a, vt[v].b, vt[v].c);
            req_valid = 2'(1) << vt[v].lane;
            rsp_ready = 2'b11;
            #1;
            chk("tbl_ready", 64'(req_ready), 64'(2'(1) << vt[v].lane));
            @(posedge clk);
            #1;
            req_valid = '0;
            for (int j = 1; j <= 3; j++) begin
                @(posedge clk);
                #1;
                if (j < 3) begin
                    chk("tbl_early_valid", 64'(rsp_valid), 64'(0));
                end else begin
                    chk("tbl_valid", 64'(rsp_valid),
                        64'(2'(1) << vt[v].lane));
                    chk("tbl_data", 64'(lane_data(vt[v].lane)),
                        64'(vt[v].exp));
                end
            end
        end
        @(posedge clk);
        #1;
        chk("tbl_idle_busy", 64'(busy), 64'(0));

        // Both lanes requesting: strict alternation starting at lane 0.
        do_reset;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("rr_grant", 64'(req_ready),
                64'((c % 2 == 0) ? 2'b01 : 2'b10));
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        repeat (8) @(posedge clk);
        #1;
        chk("rr_drain_busy", 64'(busy), 64'(0));

        // Lane 1 backpressured: credit stops it at the FIFO depth.
        do_reset;
        rsp_ready = 2'b01;
        hs = 0;
        for (int c = 0; c < 12; c++) begin
            req_valid = 2'b10;
            put_op(1, 32'(hs), 32'd0, 32'd0);
            #1;
            if (req_ready[1]) hs++;
            @(posedge clk);
            #1;
        end
        chk("bp_hs_count", 64'(hs), 64'(4));
        req_valid = 2'b11;
        put_op(0, 32'd7, 32'd0, 32'd0);
        #1;
        chk("bp_lane0_grant", 64'(req_ready), 64'(2'b01));
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (5) @(posedge clk);
        #1;
        rsp_ready = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_drain_valid", 64'(rsp_valid[1]), 64'(1));
            chk("bp_drain_data", 64'(lane_data(1)), 64'(4 * i));
            @(posedge clk);
            #1;
        end
        chk("bp_empty", 64'(rsp_valid[1]), 64'(0));

        // Reset while two ops are in flight discards both.
        do_reset;
        rsp_ready = 2'b11;
        put_op(0, 32'd1, 32'd1, 32'd1);
        put_op(1, 32'd2, 32'd2, 32'd2);
        req_valid = 2'b01;
        @(posedge clk);
        #1;
        req_valid = 2'b10;
        @(posedge clk);
        #1;
        req_valid = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            chk("mid_rst_no_valid", 64'(rsp_valid), 64'(0));
            chk("mid_rst_no_busy", 64'(busy), 64'(0));
        end

        // Randomized traffic against the queue model.
        do_reset;
        q0.delete();
        q1.delete();
        now   = 0;
        pref  = 0;
        gc[0] = 0;
        gc[1] = 0;
        for (int c = 0; c < 400; c++) begin
            req_valid    = 2'($urandom);
            rsp_ready[0] = ($urandom_range(0, 3) != 0);
            rsp_ready[1] = ($urandom_range(0, 3) != 0);
            req_a = {$urandom, $urandom};
            req_b = {$urandom, $urandom};
            req_c = {$urandom, $urandom};
            #1;
            for (int l = 0; l < 2; l++) begin
                el[l] = req_valid[l] && (qsize(l) < 4);
                ev[l] = (qsize(l) > 0) && (qfront(l).avail <= now);
            end
            if (el == 2'b11) erdy = (pref == 0) ? 2'b01 : 2'b10;
            else erdy = el;
            eb = (qsize(0) + qsize(1)) > 0;
            chk("rnd_ready", 64'(req_ready), 64'(erdy));
            chk("rnd_valid", 64'(rsp_valid), 64'(ev));
            chk("rnd_busy", 64'(busy), 64'(eb));
            for (int l = 0; l < 2; l++) begin
                if (ev[l]) chk("rnd_data", 64'(lane_data(l)),
                               64'(qfront(l).res));
            end
            g = erdy[1] ? 1 : 0;
            @(posedge clk);
            now++;
            for (int l = 0; l < 2; l++) begin
                if (ev[l] && rsp_ready[l]) qpop(l);
            end
            if (erdy != 2'b00) begin
                e.res   = ref_res(req_a[g*32 +: 32], req_b[g*32 +: 32],
                                  req_c[g*32 +: 32]);
                e.avail = now + 3;
                qpush(g, e);
                pref  = 1 - g;
                gc[g] = gc[g] + 1;
            end
            #1;
        end

`ifdef PERF_ARB_STATS_EN
        chk("gcnt_lane0", 64'(grant_cnt[15:0]), 64'(gc[0]));
        chk("gcnt_lane1", 64'(grant_cnt[31:16]), 64'(gc[1]));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
